// File: rtl/data_inf_c_intc_s2m_mcast_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : data_inf_c_intc_s2m_mcast_if
// Brief    : Stream bundle for the single-slave to multi-master multicast router.
//            The s_* group is the producer stream and the m_* group holds the
//            NUM consumer streams. The m_data vector packs one DSIZE-wide lane
//            per channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface data_inf_c_intc_s2m_mcast_if #(
    parameter int NUM   = 8,
    parameter int DSIZE = 32
);
    logic [NUM-1:0]       s_mask;
    logic                 s_valid;
    logic [DSIZE-1:0]     s_data;
    logic                 s_last;
    logic                 s_ready;

    logic [NUM-1:0]       m_valid;
    logic [NUM*DSIZE-1:0] m_data;
    logic [NUM-1:0]       m_last;
    logic [NUM-1:0]       m_ready;

    // Router side: takes the producer stream in and drives the consumer streams.
    modport slave (
        input  s_mask, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    // Environment side: the producer and the consumers.
    modport master (
        output s_mask, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/data_inf_c_intc_s2m_mcast.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : data_inf_c_intc_s2m_mcast
// Brief    : Single-slave to multi-master stream router with multicast masks.
//            It has an optional packet-level mask lock, exactly-once delivery
//            for each selected channel, and a saturating counter of dropped
//            beats. The datapath is one registered hold stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module data_inf_c_intc_s2m_mcast #(
    parameter int NUM      = 8,
    parameter int DSIZE    = 32,
    parameter int PKT_MODE = 1,
    parameter int CSIZE    = 16
) (
    input  wire                               clock,
    input  wire                               rst,
    data_inf_c_intc_s2m_mcast_if.slave        bus,
    output logic [CSIZE-1:0]                  drop_cnt,
    output logic                              busy
);

    localparam logic [CSIZE-1:0] c_CNT_MAX = '1;

    logic             r_hold_valid;
    logic [NUM-1:0]   r_pending;
    logic [DSIZE-1:0] r_hold_data;
    logic             r_hold_last;
    logic             r_in_pkt;
    logic [NUM-1:0]   r_lock_mask;
    logic [CSIZE-1:0] r_drop_cnt;

    logic [NUM-1:0]   w_eff_mask;
    logic [NUM-1:0]   w_left;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;

    // Accept-side decode: effective mask, residual deliveries, and load/drop.
    always_comb begin
        w_eff_mask = bus.s_mask;
        if ((PKT_MODE != 0) && r_in_pkt) begin
            w_eff_mask = r_lock_mask;
        end
        // Channels still owed the held beat after this cycle's handshakes.
        w_left    = r_pending & ~bus.m_ready;
        w_s_ready = !r_hold_valid || (w_left == '0);
        w_accept  = bus.s_valid && w_s_ready;
        w_load    = w_accept && (w_eff_mask != '0);
        w_drop    = w_accept && (w_eff_mask == '0);
    end

    // Control state: hold occupancy, per-channel pending, packet lock, drops.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_pending    <= '0;
            r_in_pkt     <= 1'b0;
            r_lock_mask  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_load) begin
                // Every pending bit is clearing this cycle, so the new beat
                // takes over the whole stage.
                r_hold_valid <= 1'b1;
                r_pending    <= w_eff_mask;
            end else if (r_hold_valid) begin
                r_pending <= w_left;
                if (w_left == '0) begin
                    r_hold_valid <= 1'b0;
                end
            end

            if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + CSIZE'(1);
            end

            // The packet lock is only taken when a packet spans several beats.
            if ((PKT_MODE != 0) && w_accept) begin
                if (bus.s_last) begin
                    r_in_pkt <= 1'b0;
                end else if (!r_in_pkt) begin
                    r_in_pkt    <= 1'b1;
                    r_lock_mask <= bus.s_mask;
                end
            end
        end
    end

    // Payload register: loaded only with beats that have somewhere to go.
    always_ff @(posedge clock) begin
        if (w_load) begin
            r_hold_data <= bus.s_data;
            r_hold_last <= bus.s_last;
        end
    end

    // Every channel sees the same held payload. Only its valid bit differs.
    generate
        for (genvar k = 0; k < NUM; k++) begin : g_mdata
            assign bus.m_data[k*DSIZE +: DSIZE] = r_hold_data;
        end
    endgenerate

    assign bus.m_valid = r_pending & {NUM{r_hold_valid}};
    assign bus.m_last  = {NUM{r_hold_last}};
    assign bus.s_ready = w_s_ready;
    assign drop_cnt    = r_drop_cnt;
    assign busy        = r_hold_valid | r_in_pkt;

endmodule
`default_nettype wire
